dram_cycle_sequencer: RTL and testbench
=======================================

DRAM_CYCLE_SEQUENCER -- requirements
Module: dram_cycle_sequencer

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 234, meaning clocks between refresh requests (legal range 16..1023).
REQ-002 SHALL have parameter CAS_CYCLES, default 2, meaning CAS-low cycles per CPU access (legal range 1..7).
REQ-003 SHALL have parameter PRECHARGE_CYCLES, default 2, meaning RAS/CAS-high cycles after every cycle (legal range 1..7).
REQ-004 SHALL have parameter REF_RAS_CYCLES, default 3, meaning RAS-low cycles per refresh (legal range 1..7).
REQ-005 Ports SHALL be:
  clk  in  1  single clock, all state changes on rising edge
  clr  in  1  reset, asynchronous, active-high
  cpu_req  in  1  level access request, held by requester until ack
  cpu_we  in  1  1 = write, sampled on acceptance
  ras_n  out  1  DRAM RAS strobe, active-low
  cas_n  out  1  DRAM CAS strobe, active-low
  we_n  out  1  DRAM write enable, active-low
  mux_sel  out  1  select for 2-to-1 address muxes: 0 = row, 1 = column
  mux_strobe_n  out  1  strobe for address muxes, active-low (1 = mux outputs forced low)
  ref_oe_n  out  1  enable for refresh-row address driver, active-low
  ref_row  out  7  current refresh row
  ack  out  1  one-cycle access-complete pulse
  busy  out  1  high whenever state != IDLE
  ref_overrun  out  1  sticky refresh-miss flag

Function
REQ-006 States SHALL be IDLE, ROW, COL, CAS, PRE, REF_SETUP, REF_RAS.
REQ-007 IDLE: ras_n=1, cas_n=1, we_n=1, mux_sel=0, mux_strobe_n=0, ref_oe_n=1, ack=0.
REQ-008 IDLE transitions: ref_pending=1 -> REF_SETUP; else cpu_req=1 -> ROW, latching cpu_we; else stay. Refresh wins when both are present on the same edge.
REQ-009 ROW (1 cycle): ras_n=0, mux_sel=0 -> COL.
REQ-010 COL (1 cycle): ras_n=0, mux_sel=1 -> CAS.
REQ-011 CAS (CAS_CYCLES cycles): ras_n=0, cas_n=0, mux_sel=1, we_n=~latched_we; ack=1 only in final CAS cycle -> PRE.
REQ-012 PRE (PRECHARGE_CYCLES cycles): all strobes high, mux_sel=0 -> IDLE.
REQ-013 REF_SETUP (1 cycle): ras_n=1, mux_strobe_n=1, ref_oe_n=0; ref_pending cleared on entry -> REF_RAS.
REQ-014 REF_RAS (REF_RAS_CYCLES cycles): ras_n=0, cas_n=1, mux_strobe_n=1, ref_oe_n=0 -> PRE; ref_row increments on exit, wrapping 127 -> 0.
REQ-015 cas_n SHALL never be low in any refresh state; ref_oe_n and mux_strobe_n SHALL never be low together.
REQ-016 Interval counter SHALL load REFRESH_INTERVAL-1 at reset, decrement every clock, and on reaching 0 reload and set ref_pending on the same edge.
REQ-017 If expiry occurs while ref_pending=1, ref_overrun SHALL set and stay 1 until clr; the pending request is not duplicated.
REQ-018 cpu_req still high on return to IDLE SHALL be treated as a new request (back-to-back accesses allowed); cpu_req dropped before acceptance SHALL be ignored.
REQ-019 cpu_req and cpu_we changes during a cycle SHALL NOT affect the cycle in progress.
REQ-020 All outputs SHALL be registered (glitch-free strobes).

Reset
REQ-021 clr=1 SHALL asynchronously force IDLE, IDLE output values, ack=0, busy=0, ref_row=0, ref_pending=0, ref_overrun=0, interval counter=REFRESH_INTERVAL-1, including mid-cycle.
REQ-022 First edge after clr falls SHALL be a normal IDLE evaluation.

Verification (defaults)
REQ-023 Read: cpu_req=1, cpu_we=0 sampled at edge E0 -> ROW E1, COL E2, cas_n=0 E3-E4, ack=1 E4 only, we_n=1 throughout, PRE E5-E6, IDLE E7.
REQ-024 Refresh: after clr release with cpu_req=0 -> ref_pending at edge 234, REF_SETUP 235, ras_n=0 edges 236-238 with ref_oe_n=0, ref_row 0->1, IDLE at 241; after 128 refreshes ref_row=0.
REQ-025 Collision: cpu_req=1 on the same edge ref_pending sets -> refresh sequence first; the CPU write (we_n=0 during CAS) follows immediately after its PRE; ack exactly once.
REQ-026 Overrun: cpu_req held with back-to-back accesses while refresh is forced late (REFRESH_INTERVAL=16, PRECHARGE_CYCLES=7) -> ref_overrun=1 and sticky until clr.
REQ-027 Reset mid-CAS: clr=1 while cas_n=0 -> ras_n=cas_n=1, ack=0, busy=0 before the next edge; normal access completes after release.
REQ-028 Invariant checks on all runs: no cas_n=0 while ras_n=1, no ref_oe_n=0 with mux_strobe_n=0, ack width exactly 1 cycle.

Source files
------------

// File: rtl/dram_cycle_sequencer.sv
// dram_cycle_sequencer: RAS/CAS timing sequencer for CPU accesses with interleaved periodic refresh
module dram_cycle_sequencer #(
  parameter int REFRESH_INTERVAL = 234,
  parameter int CAS_CYCLES       = 2,
  parameter int PRECHARGE_CYCLES = 2,
  parameter int REF_RAS_CYCLES   = 3
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       cpu_req,
  input  logic       cpu_we,
  output logic       ras_n,
  output logic       cas_n,
  output logic       we_n,
  output logic       mux_sel,
  output logic       mux_strobe_n,
  output logic       ref_oe_n,
  output logic [6:0] ref_row,
  output logic       ack,
  output logic       busy,
  output logic       ref_overrun
);
  typedef enum logic [2:0] {IDLE, ROW, COL, CAS, PRE, REF_SETUP, REF_RAS} state_t;
  state_t state, nxt;
  logic [2:0] cnt, nxt_cnt;
  logic [9:0] ivl;
  logic req_q, we_q, lat_we, ref_pending, expire, accept;
  assign expire = ivl == 10'd0;
  assign accept = state == IDLE && !ref_pending && req_q;
  // cpu_req is sampled alongside ref_pending so a same-edge collision resolves to refresh
  always_comb begin
    nxt = state;
    nxt_cnt = cnt - 3'd1;
    case (state)
      IDLE: nxt = ref_pending ? REF_SETUP : req_q ? ROW : IDLE;
      ROW: nxt = COL;
      COL: begin
        nxt = CAS;
        nxt_cnt = 3'(CAS_CYCLES - 1);
      end
      CAS, REF_RAS: if (cnt == 3'd0) begin
        nxt = PRE;
        nxt_cnt = 3'(PRECHARGE_CYCLES - 1);
      end
      PRE: nxt = cnt == 3'd0 ? IDLE : PRE;
      REF_SETUP: begin
        nxt = REF_RAS;
        nxt_cnt = 3'(REF_RAS_CYCLES - 1);
      end
      default: nxt = IDLE;
    endcase
  end
  // outputs decode the next state so every strobe comes straight from a flop
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= IDLE;
      cnt <= 3'd0;
      ivl <= 10'(REFRESH_INTERVAL - 1);
      req_q <= 1'b0;
      we_q <= 1'b0;
      lat_we <= 1'b0;
      ref_pending <= 1'b0;
      ref_overrun <= 1'b0;
      ref_row <= 7'd0;
      ras_n <= 1'b1;
      cas_n <= 1'b1;
      we_n <= 1'b1;
      mux_sel <= 1'b0;
      mux_strobe_n <= 1'b0;
      ref_oe_n <= 1'b1;
      ack <= 1'b0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      cnt <= nxt_cnt;
      req_q <= cpu_req;
      we_q <= cpu_we;
      if (accept) lat_we <= we_q;
      ivl <= expire ? 10'(REFRESH_INTERVAL - 1) : ivl - 10'd1;
      ref_pending <= expire | (ref_pending & (nxt != REF_SETUP));
      ref_overrun <= ref_overrun | (expire & ref_pending);
      if (state == REF_RAS && nxt == PRE) ref_row <= ref_row + 7'd1;
      ras_n <= !(nxt inside {ROW, COL, CAS, REF_RAS});
      cas_n <= nxt != CAS;
      we_n <= !(nxt == CAS && lat_we);
      mux_sel <= nxt inside {COL, CAS};
      mux_strobe_n <= nxt inside {REF_SETUP, REF_RAS};
      ref_oe_n <= !(nxt inside {REF_SETUP, REF_RAS});
      ack <= nxt == CAS && nxt_cnt == 3'd0;
      busy <= nxt != IDLE;
    end
  end
endmodule

// File: tb/tb_dram_cycle_sequencer.sv
// tb_dram_cycle_sequencer: directed vectors for access, refresh, collision, overrun and reset cases
module tb_dram_cycle_sequencer;
  logic clk = 1'b0, clr = 1'b1, cpu_req = 1'b0, cpu_we = 1'b0;
  logic ras_n, cas_n, we_n, mux_sel, mux_strobe_n, ref_oe_n, ack, busy, ref_overrun;
  logic [6:0] ref_row;
  logic ov_clr = 1'b1, ov_req = 1'b0;
  logic ov_ras_n, ov_cas_n, ov_we_n, ov_mux_sel, ov_mux_strobe_n, ov_ref_oe_n, ov_ack, ov_busy, ov_ref_overrun;
  logic [6:0] ov_ref_row;
  logic [7:0] obs;
  assign obs = {ras_n, cas_n, we_n, mux_sel, mux_strobe_n, ref_oe_n, ack, busy};
  always #5 clk = ~clk;

  dram_cycle_sequencer dut (
    .clk(clk), .clr(clr), .cpu_req(cpu_req), .cpu_we(cpu_we),
    .ras_n(ras_n), .cas_n(cas_n), .we_n(we_n), .mux_sel(mux_sel),
    .mux_strobe_n(mux_strobe_n), .ref_oe_n(ref_oe_n), .ref_row(ref_row),
    .ack(ack), .busy(busy), .ref_overrun(ref_overrun)
  );

  dram_cycle_sequencer #(
    .REFRESH_INTERVAL(16), .CAS_CYCLES(7), .PRECHARGE_CYCLES(7), .REF_RAS_CYCLES(1)
  ) u_ov (
    .clk(clk), .clr(ov_clr), .cpu_req(ov_req), .cpu_we(1'b1),
    .ras_n(ov_ras_n), .cas_n(ov_cas_n), .we_n(ov_we_n), .mux_sel(ov_mux_sel),
    .mux_strobe_n(ov_mux_strobe_n), .ref_oe_n(ov_ref_oe_n), .ref_row(ov_ref_row),
    .ack(ov_ack), .busy(ov_busy), .ref_overrun(ov_ref_overrun)
  );

  typedef struct {
    logic       we;
    int         k;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[14];

  localparam logic [7:0] O_IDLE = 8'b11100100, O_ROW = 8'b01100101, O_COL = 8'b01110101,
                         O_CASR = 8'b00110101, O_ACKR = 8'b00110111, O_CASW = 8'b00010101,
                         O_ACKW = 8'b00010111, O_PRE = 8'b11100101, O_RSET = 8'b11101001,
                         O_RRAS = 8'b01101001;

  int checks = 0, errors = 0, inv_checks = 0, inv_errors = 0, now_edge = 0, acks = 0, acks0 = 0;
  logic prev_ack = 1'b0, prev_ov_ack = 1'b0;

  always @(negedge clk) begin
    if (!clr) begin
      inv_checks++;
      if ((!cas_n && ras_n) || (!ref_oe_n && !mux_strobe_n) || (ack && prev_ack)) begin
        inv_errors++;
        $display("FAIL invariant t=%0t ras_n=%b cas_n=%b ref_oe_n=%b mux_strobe_n=%b ack=%b prev_ack=%b required: cas under ras, exclusive enables, 1-cycle ack",
                 $time, ras_n, cas_n, ref_oe_n, mux_strobe_n, ack, prev_ack);
      end
      if (ack) acks++;
    end
    if (!ov_clr) begin
      inv_checks++;
      if ((!ov_cas_n && ov_ras_n) || (!ov_ref_oe_n && !ov_mux_strobe_n) || (ov_ack && prev_ov_ack)) begin
        inv_errors++;
        $display("FAIL ov_invariant t=%0t ras_n=%b cas_n=%b ref_oe_n=%b mux_strobe_n=%b ack=%b",
                 $time, ov_ras_n, ov_cas_n, ov_ref_oe_n, ov_mux_strobe_n, ov_ack);
      end
    end
    prev_ack = clr ? 1'b0 : ack;
    prev_ov_ack = ov_clr ? 1'b0 : ov_ack;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    now_edge += n;
    #1;
  endtask

  task automatic goto(input int e);
    adv(e - now_edge);
  endtask

  task automatic do_reset;
    @(negedge clk);
    clr = 1'b1;
    cpu_req = 1'b0;
    cpu_we = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    now_edge = 0;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1, O_ROW};  tbl[1] = '{1'b0, 2, O_COL};  tbl[2] = '{1'b0, 3, O_CASR};
    tbl[3] = '{1'b0, 4, O_ACKR}; tbl[4] = '{1'b0, 5, O_PRE};  tbl[5] = '{1'b0, 6, O_PRE};
    tbl[6] = '{1'b0, 7, O_IDLE};
    tbl[7] = '{1'b1, 1, O_ROW};  tbl[8] = '{1'b1, 2, O_COL};  tbl[9] = '{1'b1, 3, O_CASW};
    tbl[10] = '{1'b1, 4, O_ACKW}; tbl[11] = '{1'b1, 5, O_PRE}; tbl[12] = '{1'b1, 6, O_PRE};
    tbl[13] = '{1'b1, 7, O_IDLE};

    #12;
    chk("rst_obs", 32'(obs), 32'(O_IDLE));
    chk("rst_row", 32'(ref_row), 0);
    chk("rst_overrun", 32'(ref_overrun), 0);
    @(negedge clk);
    clr = 1'b0;
    ov_clr = 1'b0;
    ov_req = 1'b1;
    now_edge = 0;
    adv(1);
    chk("idle_e1", 32'(obs), 32'(O_IDLE));
    chk("ov_early", 32'(ov_ref_overrun), 0);
    for (int i = 0; i < 2000 && !ov_ref_overrun; i++) adv(1);
    chk("ov_set", 32'(ov_ref_overrun), 1);
    adv(100);
    chk("ov_sticky", 32'(ov_ref_overrun), 1);
    ov_req = 1'b0;
    ov_clr = 1'b1;
    #1;
    chk("ov_clr", 32'(ov_ref_overrun), 0);

    do_reset;
    for (int i = 0; i < 14; i++) begin
      if (tbl[i].k == 1) begin
        cpu_req = 1'b1;
        cpu_we = tbl[i].we;
        adv(1);
      end
      adv(1);
      chk($sformatf("acc%0d_e%0d", i / 7, tbl[i].k), 32'(obs), 32'(tbl[i].exp));
      if (tbl[i].k == 4) cpu_req = 1'b0;
    end

    do_reset;
    goto(234); chk("ref_234", 32'(obs), 32'(O_IDLE));
    goto(235); chk("ref_setup", 32'(obs), 32'(O_RSET));
    goto(236); chk("ref_ras236", 32'(obs), 32'(O_RRAS));
    goto(238); chk("ref_ras238", 32'(obs), 32'(O_RRAS));
    chk("ref_row238", 32'(ref_row), 0);
    goto(239); chk("ref_pre239", 32'(obs), 32'(O_PRE));
    chk("ref_row239", 32'(ref_row), 1);
    goto(241); chk("ref_idle241", 32'(obs), 32'(O_IDLE));
    goto(29956); chk("ref_row127", 32'(ref_row), 127);
    goto(29957); chk("ref_row_wrap", 32'(ref_row), 0);
    chk("no_overrun", 32'(ref_overrun), 0);

    do_reset;
    acks0 = acks;
    goto(233);
    cpu_req = 1'b1;
    cpu_we = 1'b1;
    goto(235); chk("col_setup", 32'(obs), 32'(O_RSET));
    goto(241); chk("col_idle", 32'(obs), 32'(O_IDLE));
    goto(242); chk("col_row", 32'(obs), 32'(O_ROW));
    goto(244); chk("col_casw", 32'(obs), 32'(O_CASW));
    goto(245); chk("col_ackw", 32'(obs), 32'(O_ACKW));
    cpu_req = 1'b0;
    goto(260); chk("col_acks", 32'(acks - acks0), 1);

    do_reset;
    cpu_req = 1'b1;
    goto(4); chk("mid_cas", 32'(cas_n), 0);
    #2 clr = 1'b1;
    #1 chk("mid_rst", 32'(obs), 32'(O_IDLE));
    @(negedge clk);
    clr = 1'b0;
    now_edge = 0;
    goto(2); chk("rel_row", 32'(obs), 32'(O_ROW));
    goto(4); chk("rel_cas", 32'(obs), 32'(O_CASR));
    goto(5); chk("rel_ack", 32'(obs), 32'(O_ACKR));
    cpu_req = 1'b0;
    goto(8); chk("rel_idle", 32'(obs), 32'(O_IDLE));

    $display("Result: errors=%0d of %0d checks", errors + inv_errors, checks + inv_checks);
    $finish;
  end
endmodule
